// File: rtl/moving_sum.sv
// Boxcar moving sum over the last LEN accepted samples, fed by an external LEN-deep delay line.
// Output registered one cycle after ce; delay-line output masked until the first window fills.
module moving_sum #(
   parameter int DATA_WIDTH = 25,
   parameter int LEN        = 512
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   ce,
   input  logic                                   clr,
   input  logic [DATA_WIDTH-1:0]                  di,
   input  logic [DATA_WIDTH-1:0]                  di_dly,
   output logic [DATA_WIDTH+$clog2(LEN)-1:0]      sum_o,
   output logic                                   valid_o,
   output logic                                   full_o
);

   localparam int OUT_WIDTH = DATA_WIDTH + $clog2(LEN);
   localparam int CW        = $clog2(LEN);
   localparam int EXT       = OUT_WIDTH - DATA_WIDTH;
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);

   typedef enum logic {FILL, RUN} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0]   acc_q, acc_d;
   logic                   valid_q, valid_d;
   logic [OUT_WIDTH-1:0]   di_ext, dly_ext;
   logic                   fill_done;

   assign fill_done = ce && (state_q == FILL) && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FILL;
         cnt_q   <= '0;
         acc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = FILL;
      end else if (fill_done) begin
         state_d = RUN;
      end
   end

   // Delay-line output is undefined until the window has filled once, so it is forced to zero in FILL.
   always_comb begin
      di_ext  = {{EXT{di[DATA_WIDTH-1]}}, di};
      dly_ext = '0;
      if (state_q == RUN) begin
         dly_ext = {{EXT{di_dly[DATA_WIDTH-1]}}, di_dly};
      end

      acc_d   = acc_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (ce) begin
         acc_d   = acc_q + di_ext - dly_ext;
         valid_d = (state_q == RUN) || fill_done;
         if (state_q == FILL && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      sum_o   = acc_q;
      valid_o = valid_q;
      full_o  = (state_q == RUN);
   end

endmodule

// File: tb/tb_moving_sum.sv
// Directed bench for moving_sum with DATA_WIDTH=8, LEN=4 and an ideal delay-line model.
module tb_moving_sum;

   localparam int DW  = 8;
   localparam int LEN = 4;
   localparam int OW  = DW + $clog2(LEN);

   logic          clk;
   logic          rst_n;
   logic          ce;
   logic          clr;
   logic [DW-1:0] di;
   logic [DW-1:0] di_dly;
   logic [OW-1:0] sum_o;
   logic          valid_o;
   logic          full_o;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] hist[$];

   moving_sum #(.DATA_WIDTH(DW), .LEN(LEN)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce      (ce),
      .clr     (clr),
      .di      (di),
      .di_dly  (di_dly),
      .sum_o   (sum_o),
      .valid_o (valid_o),
      .full_o  (full_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one sample with the ideal delayed value (0x55 garbage before the window fills).
   task automatic send(input logic [DW-1:0] d);
      ce = 1'b1;
      di = d;
      di_dly = (hist.size() >= LEN) ? hist[hist.size()-LEN] : 8'h55;
      @(posedge clk); #1;
      hist.push_back(d);
      ce = 1'b0;
      di = '0;
      di_dly = 8'h55;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      hist.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; ce = 1'b0; di = '0; di_dly = 8'h55;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sum_o !== '0 || valid_o !== 1'b0 || full_o !== 1'b0) begin
         errors++;
         $display("FAIL reset: sum=%0d valid=%b full=%b expected 0 0 0", $signed(sum_o), valid_o, full_o);
      end
      rst_n = 1'b1;
      hist.delete();
   endtask

   task automatic test_fill_run();
      int exp_sum[6] = '{1, 3, 6, 10, 14, 18};
      logic exp_v[6] = '{0, 0, 0, 1, 1, 1};
      for (int i = 0; i < 6; i++) begin
         send(DW'(i + 1));
         checks++;
         if (sum_o !== OW'(exp_sum[i]) || valid_o !== exp_v[i] || full_o !== exp_v[i]) begin
            errors++;
            $display("FAIL fill_run[%0d]: sum=%0d valid=%b full=%b expected %0d %b %b",
                     i, $signed(sum_o), valid_o, full_o, exp_sum[i], exp_v[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_negative();
      int exp_sum[6] = '{-128, -256, -384, -512, -512, -512};
      do_clr();
      for (int i = 0; i < 6; i++) begin
         send(8'h80);
         checks++;
         if (sum_o !== OW'(exp_sum[i]) || valid_o !== (i >= 3)) begin
            errors++;
            $display("FAIL negative[%0d]: sum=%0d valid=%b expected %0d %b",
                     i, $signed(sum_o), valid_o, exp_sum[i], (i >= 3));
         end
      end
   endtask

   task automatic test_ce_gaps();
      int exp_sum[6] = '{1, 3, 6, 10, 14, 18};
      do_clr();
      for (int i = 0; i < 6; i++) begin
         send(DW'(i + 1));
         checks++;
         if (sum_o !== OW'(exp_sum[i]) || valid_o !== (i >= 3)) begin
            errors++;
            $display("FAIL gaps_ce[%0d]: sum=%0d valid=%b expected %0d %b",
                     i, $signed(sum_o), valid_o, exp_sum[i], (i >= 3));
         end
         for (int g = 0; g < 3; g++) begin
            @(posedge clk); #1;
            checks++;
            if (sum_o !== OW'(exp_sum[i]) || valid_o !== 1'b0) begin
               errors++;
               $display("FAIL gaps_hold[%0d.%0d]: sum=%0d valid=%b expected %0d 0",
                        i, g, $signed(sum_o), valid_o, exp_sum[i]);
            end
         end
      end
   endtask

   task automatic test_clr_mid_run();
      int exp_sum[5] = '{1, 2, 3, 4, 4};
      clr = 1'b1; ce = 1'b1; di = 8'd7; di_dly = 8'd3;
      @(posedge clk); #1;
      clr = 1'b0; ce = 1'b0; di = '0; di_dly = 8'h55;
      hist.delete();
      checks++;
      if (sum_o !== '0 || valid_o !== 1'b0 || full_o !== 1'b0) begin
         errors++;
         $display("FAIL clr_run: sum=%0d valid=%b full=%b expected 0 0 0", $signed(sum_o), valid_o, full_o);
      end
      for (int i = 0; i < 5; i++) begin
         send(8'd1);
         checks++;
         if (sum_o !== OW'(exp_sum[i]) || valid_o !== (i >= 3) || full_o !== (i >= 3)) begin
            errors++;
            $display("FAIL clr_refill[%0d]: sum=%0d valid=%b full=%b expected %0d %b %b",
                     i, $signed(sum_o), valid_o, full_o, exp_sum[i], (i >= 3), (i >= 3));
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      do_clr();
      send(8'd5);
      send(8'd6);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      hist.delete();
      checks++;
      if (sum_o !== '0 || valid_o !== 1'b0 || full_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_fill: sum=%0d valid=%b full=%b expected 0 0 0", $signed(sum_o), valid_o, full_o);
      end
      for (int i = 0; i < 4; i++) begin
         send(8'd2);
         checks++;
         if (sum_o !== OW'(2 * (i + 1)) || valid_o !== (i == 3) || full_o !== (i == 3)) begin
            errors++;
            $display("FAIL rst_refill[%0d]: sum=%0d valid=%b full=%b expected %0d %b %b",
                     i, $signed(sum_o), valid_o, full_o, 2 * (i + 1), (i == 3), (i == 3));
         end
      end
   endtask

   task automatic test_priority();
      rst_n = 1'b0; clr = 1'b1; ce = 1'b1; di = 8'd9; di_dly = 8'd2;
      @(posedge clk); #1;
      rst_n = 1'b1; clr = 1'b0; ce = 1'b0; di = '0; di_dly = 8'h55;
      hist.delete();
      checks++;
      if (sum_o !== '0 || valid_o !== 1'b0 || full_o !== 1'b0) begin
         errors++;
         $display("FAIL priority: sum=%0d valid=%b full=%b expected 0 0 0", $signed(sum_o), valid_o, full_o);
      end
      send(8'd3);
      checks++;
      if (sum_o !== OW'(3) || valid_o !== 1'b0 || full_o !== 1'b0) begin
         errors++;
         $display("FAIL priority_after: sum=%0d valid=%b full=%b expected 3 0 0", $signed(sum_o), valid_o, full_o);
      end
   endtask

   initial begin
      test_reset();
      test_fill_run();
      test_negative();
      test_ce_gaps();
      test_clr_mid_run();
      test_reset_mid_fill();
      test_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
